stim_vector_sequencer: RTL and testbench
========================================

// Module: stim_vector_sequencer
// PURPOSE
//  Sequences the fuzz-DUT input bus through a table of NUM_VEC stimulus vectors.
//  For each vector it fetches the entry, drives it onto dut_in, waits SETTLE clocks,
//  captures dut_out and streams the capture out on a valid/ready port.
//  It keeps a running signature over all captures so synthesized and reference
//  runs compare by one word. Sits between the vector ROM, the DUT top and the result sink.
// PARAMETERS
//  IN_W     64   DUT input bus width ({wire3,wire2,wire1,wire0} = 15+9+21+19)
//  OUT_W    242  DUT output width (y)
//  NUM_VEC  21   vectors per run, >=1
//  ADDR_W   5    vector address width, 2**ADDR_W >= NUM_VEC
//  SETTLE   1    clocks dut_in is held before capture, >=1
//  TIMEOUT  16   stall limit in cycles; used only with SEQ_TIMEOUT_EN
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous active-high reset
//  start      in   1       begin a run; sampled only in IDLE
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle pulse at end of run
//  vec_rd     out  1       vector read strobe
//  vec_addr   out  ADDR_W  vector index
//  vec_data   in   IN_W    vector, valid the cycle after vec_rd
//  dut_in     out  IN_W    registered DUT stimulus
//  dut_out    in   OUT_W   DUT response
//  res_valid  out  1       capture available
//  res_ready  in   1       sink accepts capture
//  res_data   out  OUT_W   captured dut_out
//  res_idx    out  ADDR_W  vector index of res_data
//  signature  out  OUT_W   running signature
//  err        out  1       sticky timeout flag (0 without SEQ_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, vec_rd, res_valid and err are 0.
//   vec_addr, dut_in, res_data, res_idx and signature are all 0. Reset wins over every other event.
//   A mid-run reset aborts the run; no done pulse.
//  FSM states: IDLE, FETCH, LOAD, SETTLE, EMIT, DONE.
//   IDLE: if start, then idx=0 and signature=0 -> FETCH.
//    start in any other state is ignored.
//   FETCH: vec_rd=1, vec_addr=idx for exactly one cycle -> LOAD.
//   LOAD: dut_in<=vec_data and cnt=SETTLE-1 -> SETTLE.
//   SETTLE: if cnt!=0, then cnt-- and stay. If cnt==0, on that edge:
//    res_data<=dut_out, res_idx<=idx, res_valid<=1,
//    signature<={signature[OUT_W-2:0],signature[OUT_W-1]} ^ dut_out -> EMIT.
//   EMIT: res_valid, res_data and res_idx are held stable until res_valid&&res_ready.
//    On handshake, res_valid<=0. If idx==NUM_VEC-1 -> DONE; else idx++ -> FETCH.
//   DONE: done=1 for one cycle -> IDLE. dut_in keeps the last vector.
//  Timing: FETCH occupies the first cycle after the edge that samples start.
//   With res_ready high, each vector takes 3+SETTLE cycles.
//   A full run takes NUM_VEC*(3+SETTLE) cycles, then the DONE cycle.
//  res_ready low stalls EMIT indefinitely. Stalls do not alter the signature.
//  The first capture is never taken before dut_in has been held SETTLE full cycles.
//  idx never wraps. Width rules: idx is ADDR_W bits; the signature is an XOR of OUT_W-bit words.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: a counter runs while EMIT is stalled.
//   If res_valid has been high and unaccepted for TIMEOUT cycles, the capture is dropped.
//   The signature keeps its update, err<=1 (sticky until rst), and the FSM proceeds as if accepted.
//  SEQ_TIMEOUT_EN undefined: no counter, err tied 0, EMIT waits forever.
// TESTING
//  1 Reset: hold rst 3 cycles with start=1 -> busy=0, res_valid=0, dut_in=0, signature=0.
//  2 Full run: 21-vector table, res_ready=1, SETTLE=1, dut_out=dut_in zero-extended.
//    -> 21 captures with res_idx 0..20 in order; done on cycle 85 after start.
//    -> signature matches the golden model.
//  3 Backpressure: res_ready low for 7 cycles on idx 4 -> res_data/res_idx stable.
//    -> run ends 7 cycles later; signature identical to scenario 2.
//  4 Start while busy: pulse start at idx 10 -> ignored; one done only, 21 captures.
//  5 Mid-run reset: rst at idx 12 -> all outputs to reset values next edge, no done.
//    A new start then yields res_idx 0 first.
//  6 SEQ_TIMEOUT_EN, TIMEOUT=16: res_ready=0 throughout -> each vector advances after 16 stall cycles.
//    -> err=1 after first timeout; done still pulses.

Source files
------------

// File: rtl/stim_vector_sequencer.sv
// Walks a stimulus-vector table onto the DUT input bus, captures each response,
// streams it out on valid/ready and folds it into a rotate-XOR signature.
// Optional stall timeout: define SEQ_TIMEOUT_EN.
module stim_vector_sequencer #(
  parameter int IN_W    = 64,
  parameter int OUT_W   = 242,
  parameter int NUM_VEC = 21,
  parameter int ADDR_W  = 5,
  parameter int SETTLE  = 1,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              vec_rd,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [IN_W-1:0]   vec_data,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic [ADDR_W-1:0] res_idx,
  output logic [OUT_W-1:0]  signature,
  output logic              err
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (NUM_VEC < 1 || SETTLE < 1 || TIMEOUT < 1 || (2 ** ADDR_W) < NUM_VEC) begin : g_bad_params
    $error("stim_vector_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SETTLE, S_EMIT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [IN_W-1:0]    dut_in_q;
  logic [OUT_W-1:0]   res_data_q;
  logic [ADDR_W-1:0]  res_idx_q;
  logic [OUT_W-1:0]   sig_q;
  logic               timeout_hit;
  logic               emit_go;
  logic               last_vec;

  assign last_vec = (idx_q == ADDR_W'(NUM_VEC - 1));
  assign emit_go  = res_ready || timeout_hit;

`ifdef SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_q;
  logic            err_q;

  // Fires on the TIMEOUT-th consecutive cycle the capture sits unaccepted.
  assign timeout_hit = (state_q == S_EMIT) && !res_ready && (to_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_EMIT && !res_ready && !timeout_hit) to_q <= to_q + 1'b1;
      else to_q <= '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_LOAD;
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == '0) state_d = S_EMIT;
      S_EMIT:   if (emit_go) state_d = last_vec ? S_DONE : S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    vec_rd    = (state_q == S_FETCH);
    res_valid = (state_q == S_EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      dut_in_q   <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
      sig_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          idx_q <= '0;
          sig_q <= '0;
        end
        S_LOAD: begin
          dut_in_q <= vec_data;
          cnt_q    <= CNT_W'(SETTLE - 1);
        end
        S_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            res_data_q <= dut_out;
            res_idx_q  <= idx_q;
            sig_q      <= {sig_q[OUT_W-2:0], sig_q[OUT_W-1]} ^ dut_out;
          end
        end
        S_EMIT: if (emit_go && !last_vec) idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign vec_addr  = idx_q;
  assign dut_in    = dut_in_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_stim_vector_sequencer.sv
// Bench for stim_vector_sequencer: vector table, loopback DUT (zero-extended dut_in),
// capture scoreboard and an arithmetic signature model.
module tb_stim_vector_sequencer;
  localparam int IN_W = 64, OUT_W = 242, NV = 21, AW = 5;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
  logic busy, done, vec_rd, res_valid, err;
  logic [AW-1:0]    vec_addr, res_idx;
  logic [IN_W-1:0]  vec_data = '0, dut_in;
  logic [OUT_W-1:0] dut_out, res_data, signature;

  always #5 clk = ~clk;

  stim_vector_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .vec_rd(vec_rd), .vec_addr(vec_addr), .vec_data(vec_data),
    .dut_in(dut_in), .dut_out(dut_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .signature(signature), .err(err)
  );

  typedef struct {
    logic [IN_W-1:0]  vin;
    logic [OUT_W-1:0] exp_data;
    logic [AW-1:0]    exp_idx;
  } vec_rec_t;

  vec_rec_t tbl [NV];
  logic [IN_W-1:0] rom [32];
  int n_cmp = 0, n_bad = 0;

  typedef struct { logic [OUT_W-1:0] d; logic [AW-1:0] i; } cap_t;
  cap_t cap_q [$];

  assign dut_out = {{(OUT_W-IN_W){1'b0}}, dut_in};

  always @(posedge clk) if (vec_rd) vec_data <= rom[vec_addr];

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard capture and hold-stability monitor, sampled mid-cycle.
  logic             held_v = 1'b0;
  logic [OUT_W-1:0] held_d;
  logic [AW-1:0]    held_i;
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && res_valid) begin
        chk("hold_data", res_data, held_d);
        chk("hold_idx", OUT_W'(res_idx), OUT_W'(held_i));
      end
      if (res_valid && res_ready) cap_q.push_back('{d: res_data, i: res_idx});
      held_v = res_valid && !res_ready;
      held_d = res_data;
      held_i = res_idx;
    end
  end

  function automatic logic [OUT_W-1:0] sig_model();
    logic [OUT_W-1:0] s = '0;
    for (int i = 0; i < NV; i++)
      s = ((s << 1) | (s >> (OUT_W-1))) ^ tbl[i].exp_data;
    return s;
  endfunction

  task automatic fill_table(input bit corners);
    for (int i = 0; i < NV; i++) begin
      tbl[i].vin = {$urandom, $urandom};
      if (corners && i == 0)      tbl[i].vin = '0;
      if (corners && i == 1)      tbl[i].vin = '1;
      if (corners && i == NV-1)   tbl[i].vin = 64'h8000_0000_0000_0001;
      tbl[i].exp_data = {{(OUT_W-IN_W){1'b0}}, tbl[i].vin};
      tbl[i].exp_idx  = AW'(i);
      rom[i] = tbl[i].vin;
    end
  endtask

  task automatic check_caps(input int n_exp);
    int n;
    chk("cap_count", OUT_W'(cap_q.size()), OUT_W'(n_exp));
    n = (cap_q.size() < n_exp) ? cap_q.size() : n_exp;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("cap%0d_idx", i), OUT_W'(cap_q[i].i), OUT_W'(tbl[i].exp_idx));
      chk($sformatf("cap%0d_data", i), cap_q[i].d, tbl[i].exp_data);
    end
  endtask

  // mode 0: ready high; 1: 7-cycle stall on idx 4; 2: random ready;
  // 3: reset at idx 12; 4: ready held low.
  task automatic run_seq(input int mode, input int pulse_idx, output int done_cyc, output int ndone);
    int cyc = 1, stall = 0;
    bit stalled_once = 0;
    done_cyc = -1;
    ndone = 0;
    cap_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 3000 && done_cyc < 0) begin
      if (mode == 3 && res_valid && res_idx == AW'(12)) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", OUT_W'(busy), '0);
        chk("abort_valid", OUT_W'(res_valid), '0);
        chk("abort_done", OUT_W'(done), '0);
        chk("abort_dut_in", OUT_W'(dut_in), '0);
        chk("abort_sig", signature, '0);
        chk("abort_res", res_data, '0);
        chk("abort_ridx", OUT_W'(res_idx), '0);
        chk("abort_addr", OUT_W'(vec_addr), '0);
        rst = 1'b0;
        return;
      end
      if (mode == 1 && res_valid && res_idx == AW'(4) && !stalled_once) begin
        stall = 7;
        stalled_once = 1;
      end
      if (stall > 0) begin
        res_ready = 1'b0;
        stall--;
      end else if (mode == 2) res_ready = 1'($urandom_range(0, 1));
      else if (mode == 4)     res_ready = 1'b0;
      else                    res_ready = 1'b1;
      start = (pulse_idx >= 0 && busy && res_idx == AW'(pulse_idx)) ? 1'b1 : 1'b0;
      if (done) begin
        done_cyc = cyc;
        ndone++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (done_cyc < 0) chk("run_timeout", 1, 0);
    chk("idle_after_done", OUT_W'(busy), '0);
    for (int k = 0; k < 10; k++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int dc, nd;
    logic [OUT_W-1:0] sig_ref;
    fill_table(1'b1);
    for (int i = NV; i < 32; i++) rom[i] = '0;

    // Reset held with start asserted.
    rst = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", OUT_W'(busy), '0);
    chk("rst_valid", OUT_W'(res_valid), '0);
    chk("rst_dut_in", OUT_W'(dut_in), '0);
    chk("rst_sig", signature, '0);
    chk("rst_done", OUT_W'(done), '0);
    chk("rst_err", OUT_W'(err), '0);
    chk("rst_vec_rd", OUT_W'(vec_rd), '0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    // Full run, ready high.
    sig_ref = sig_model();
    run_seq(0, -1, dc, nd);
    chk("full_done_cyc", OUT_W'(dc), OUT_W'(85));
    chk("full_ndone", OUT_W'(nd), OUT_W'(1));
    check_caps(NV);
    chk("full_sig", signature, sig_ref);
    chk("full_dut_in_last", OUT_W'(dut_in), OUT_W'(tbl[NV-1].vin));
    $display("run full: done_cyc=%0d caps=%0d sig=%h", dc, cap_q.size(), signature);

    // Backpressure on idx 4.
    run_seq(1, -1, dc, nd);
    chk("bp_done_cyc", OUT_W'(dc), OUT_W'(92));
    check_caps(NV);
    chk("bp_sig", signature, sig_ref);
    chk("bp_err", OUT_W'(err), '0);
    $display("run backpressure: done_cyc=%0d caps=%0d", dc, cap_q.size());

    // Start pulsed while busy.
    run_seq(0, 10, dc, nd);
    chk("sb_ndone", OUT_W'(nd), OUT_W'(1));
    chk("sb_done_cyc", OUT_W'(dc), OUT_W'(85));
    check_caps(NV);
    $display("run start-while-busy: ndone=%0d caps=%0d", nd, cap_q.size());

    // Mid-run reset, then a clean restart.
    run_seq(3, -1, dc, nd);
    chk("abort_caps", OUT_W'(cap_q.size()), OUT_W'(12));
    chk("abort_ndone", OUT_W'(nd), '0);
    run_seq(0, -1, dc, nd);
    check_caps(NV);
    chk("restart_sig", signature, sig_ref);
    $display("run reset-restart: done_cyc=%0d caps=%0d", dc, cap_q.size());

    // Random table and random backpressure.
    for (int r = 0; r < 3; r++) begin
      fill_table(1'b0);
      sig_ref = sig_model();
      run_seq(2, -1, dc, nd);
      chk("rnd_ndone", OUT_W'(nd), OUT_W'(1));
      check_caps(NV);
      chk("rnd_sig", signature, sig_ref);
      $display("run random %0d: done_cyc=%0d caps=%0d", r, dc, cap_q.size());
    end

`ifdef SEQ_TIMEOUT_EN
    run_seq(4, -1, dc, nd);
    chk("to_done_cyc", OUT_W'(dc), OUT_W'(NV*19 + 1));
    chk("to_ndone", OUT_W'(nd), OUT_W'(1));
    chk("to_caps", OUT_W'(cap_q.size()), '0);
    chk("to_err", OUT_W'(err), OUT_W'(1));
    chk("to_sig", signature, sig_ref);
    $display("run timeout: done_cyc=%0d err=%0d", dc, err);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
